// File: rtl/display_mux_driver_if.sv
// display_mux_driver_if: capture strobe, BCD result and multiplexed 7-segment outputs
interface display_mux_driver_if;
  logic       load;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic [6:0] segments;
  logic       digit;
  modport master (output load, ten_count, unit_count, input segments, digit);
  modport slave (input load, ten_count, unit_count, output segments, digit);
endinterface

// File: rtl/display_mux_driver.sv
// display_mux_driver: latches a two-digit BCD result and time-multiplexes it onto one 7-segment bus
module display_mux_driver #(
  parameter int REFRESH_PERIOD     = 256,
  parameter int BLANK_LEADING_ZERO = 1,
  parameter int SEG_ACTIVE_LOW     = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  display_mux_driver_if.slave dif
);
  localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [6:0] OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  logic [3:0]    tens_q;
  logic [3:0]    units_q;
  logic          valid;
  logic [CW-1:0] refresh_cnt;
  logic          wrap;
  logic          digit_nx;
  logic [3:0]    sel_val;
  logic [6:0]    glyph;
  logic          blank;
  logic [6:0]    seg_nx;
  assign wrap = refresh_cnt == CW'(REFRESH_PERIOD - 1);
  // Decode the digit selected at this edge from the pre-edge shadow, so a fresh load shows one edge later
  always_comb begin
    digit_nx = wrap ? ~dif.digit : dif.digit;
    sel_val  = digit_nx ? tens_q : units_q;
    glyph    = 7'h79;
    case (sel_val)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      default: glyph = 7'h79;
    endcase
    blank  = !valid || (digit_nx && tens_q == 4'd0 && BLANK_LEADING_ZERO != 0);
    seg_nx = blank ? OFF : ((SEG_ACTIVE_LOW != 0) ? ~glyph : glyph);
  end
  // Shadow capture; load never touches the refresh timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      valid   <= 1'b0;
    end else if (dif.load) begin
      tens_q  <= dif.ten_count;
      units_q <= dif.unit_count;
      valid   <= 1'b1;
    end
  end
  // Refresh counter with digit select and segments registered together to avoid cross-digit glitches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt  <= '0;
      dif.digit    <= 1'b0;
      dif.segments <= OFF;
    end else begin
      refresh_cnt  <= wrap ? '0 : refresh_cnt + 1'b1;
      dif.digit    <= digit_nx;
      dif.segments <= seg_nx;
    end
  end
endmodule

// File: tb/tb_display_mux_driver.sv
// tb_display_mux_driver: randomized and directed checks of three configurations against an arithmetic model
module tb_display_mux_driver;
  localparam int N = 3;
  localparam int PA [N] = '{256, 5, 2};
  localparam int BZ [N] = '{1, 0, 1};
  localparam int AL [N] = '{0, 1, 1};
  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic load = 1'b0;
  logic [3:0] ten = 4'd0;
  logic [3:0] unit = 4'd0;
  logic [6:0] seg_o [N];
  logic       dig_o [N];
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : u
    display_mux_driver_if ifc ();
    assign ifc.load = load;
    assign ifc.ten_count = ten;
    assign ifc.unit_count = unit;
    assign seg_o[g] = ifc.segments;
    assign dig_o[g] = ifc.digit;
    display_mux_driver #(.REFRESH_PERIOD(PA[g]), .BLANK_LEADING_ZERO(BZ[g]), .SEG_ACTIVE_LOW(AL[g])) dut (
      .clk(clk),
      .reset_n(reset_n),
      .dif(ifc.slave)
    );
  end
  // Model: digit follows elapsed edges since reset; glyph comes from the result held before each edge
  int t;
  bit m_valid;
  logic [3:0] m_tens;
  logic [3:0] m_units;
  logic [6:0] exp_seg [N];
  logic       exp_dig [N];
  function automatic logic [6:0] mseg(bit d, bit v, logic [3:0] tn, logic [3:0] un, int blz, int al);
    int val;
    logic [6:0] p;
    val = d ? int'(tn) : int'(un);
    p = (!v || (d && tn == 4'd0 && blz != 0)) ? 7'h00 : (val > 9 ? 7'h79 : GLYPH[val]);
    return (al != 0) ? ~p : p;
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t = 0;
      m_valid = 0;
      m_tens = 0;
      m_units = 0;
      for (int i = 0; i < N; i++) begin
        exp_dig[i] = 1'b0;
        exp_seg[i] = (AL[i] != 0) ? 7'h7F : 7'h00;
      end
    end else begin
      t++;
      for (int i = 0; i < N; i++) begin
        exp_dig[i] = ((t / PA[i]) % 2) == 1;
        exp_seg[i] = mseg(exp_dig[i], m_valid, m_tens, m_units, BZ[i], AL[i]);
      end
      if (load) begin
        m_valid = 1;
        m_tens = ten;
        m_units = unit;
      end
    end
  end
  task automatic check(string tag);
    for (int i = 0; i < N; i++) begin
      compared++;
      assert (seg_o[i] === exp_seg[i]) else begin
        mismatched++;
        $error("FAIL %s seg[%0d] t=%0d: got %h expected %h", tag, i, t, seg_o[i], exp_seg[i]);
      end
      compared++;
      assert (dig_o[i] === exp_dig[i]) else begin
        mismatched++;
        $error("FAIL %s digit[%0d] t=%0d: got %b expected %b", tag, i, t, dig_o[i], exp_dig[i]);
      end
    end
  endtask
  task automatic run(int n, string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag);
    end
  endtask
  task automatic pulse(logic [3:0] tn, logic [3:0] un, string tag);
    @(negedge clk);
    check(tag);
    load = 1'b1;
    ten = tn;
    unit = un;
    @(negedge clk);
    check(tag);
    load = 1'b0;
    ten = 4'($urandom);
    unit = 4'($urandom);
  endtask
  initial begin
    #12 reset_n = 1'b1;
    check("reset");
    run(3 * 256 + 4, "idle");
    pulse(4'd4, 4'd2, "ld42");
    run(600, "ld42");
    pulse(4'd0, 4'd7, "ld07");
    run(520, "ld07");
    pulse(4'd12, 4'd15, "ldE");
    run(520, "ldE");
    pulse(4'd0, 4'd0, "ld00");
    run(520, "ld00");
    pulse(4'd8, 4'd1, "ld81");
    run(300, "ld81");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_rst");
    compared++;
    assert (seg_o[1] === 7'h7F) else begin
      mismatched++;
      $error("FAIL async_rst_lowseg: got %h expected 7f", seg_o[1]);
    end
    #1 reset_n = 1'b1;
    run(20, "post_rst");
    @(negedge clk);
    load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ten = 4'($urandom_range(1, 9));
      unit = 4'($urandom);
      @(negedge clk);
      check("hold_load");
    end
    load = 1'b0;
    run(600, "hold_load");
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) pulse(4'($urandom_range(0, 2)), 4'($urandom), "rand");
      else pulse(4'($urandom), 4'($urandom), "rand");
      run($urandom_range(1, 300), "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
